// File: rtl/de3d_tc_miss_sched_pkg.sv
// Shared texture-cache definitions: scheduler state encoding, bank indices and default widths.
package de3d_tc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_FILL = 2'd2,
        DONE      = 2'd3
    } tc_state_e;

    localparam logic [1:0] BANK_EE = 2'd0;
    localparam logic [1:0] BANK_EO = 2'd1;
    localparam logic [1:0] BANK_OE = 2'd2;
    localparam logic [1:0] BANK_OO = 2'd3;

    localparam int unsigned TAG_W_DEF = 5;
    localparam int unsigned MIP_W_DEF = 4;

    function automatic logic [3:0] bank_onehot(input logic [1:0] idx);
        bank_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/de3d_tc_miss_sched_if.sv
// Lookup/arbiter bundle between the tag banks, the miss scheduler and the memory arbiter.
interface de3d_tc_miss_sched_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned MIP_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic               lookup_valid;
    logic               lookup_clip;
    logic [3:0]         miss;
    logic [4*TAG_W-1:0] tag_adr;
    logic [MIP_W-1:0]   mipmap;
    logic               mem_ack;
    logic               fill_done;
    logic               stall;
    logic               mem_req;
    logic [1:0]         mem_bank;
    logic [TAG_W-1:0]   mem_tag_adr;
    logic [MIP_W-1:0]   mem_mipmap;
    logic [3:0]         tag_wr;
    logic               texel_valid;
    logic               fill_err;
    logic [CNT_W-1:0]   miss_cnt;

    modport master (
        output lookup_valid, lookup_clip, miss, tag_adr, mipmap, mem_ack, fill_done,
        input  stall, mem_req, mem_bank, mem_tag_adr, mem_mipmap, tag_wr, texel_valid,
               fill_err, miss_cnt
    );

    modport slave (
        input  lookup_valid, lookup_clip, miss, tag_adr, mipmap, mem_ack, fill_done,
        output stall, mem_req, mem_bank, mem_tag_adr, mem_mipmap, tag_wr, texel_valid,
               fill_err, miss_cnt
    );
endinterface

// File: rtl/de3d_tc_miss_sched_prio4.sv
// Lowest-set-bit priority encoder over the four tag banks (ee wins).
module de3d_tc_prio4 (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       any
);
    always_comb begin
        idx = 2'd0;
        any = |req;
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else if (req[3]) idx = 2'd3;
    end
endmodule

// File: rtl/de3d_tc_miss_sched.sv
// Texture-cache miss scheduler: serialises missing banks into fill requests, stalls the
// address pipeline until every fill lands (or times out), then releases the lookup.
module de3d_tc_miss_sched
    import de3d_tc_pkg::*;
#(
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned MIP_W   = MIP_W_DEF,
    parameter int unsigned FILL_TO = 255,
    parameter int unsigned CNT_W   = 16
) (
    input logic                 de_clk,
    input logic                 de_rstn,
    de3d_tc_miss_sched_if.slave tc
);
    localparam int unsigned WD_W = $clog2(FILL_TO);

    tc_state_e          state;
    logic [3:0]         pend_mask;
    logic [4*TAG_W-1:0] tag_q;
    logic [MIP_W-1:0]   mip_q;
    logic [WD_W-1:0]    wd;

    logic       acc;
    logic       wd_hit;
    logic [3:0] left_mask;
    logic [3:0] prio_in;
    logic [1:0] prio_idx;
    logic       prio_any;

    // The encoder looks at the incoming miss vector when accepting, and at the
    // mask with the current bank removed when deciding the next request.
    always_comb begin
        acc       = (state == IDLE) && tc.lookup_valid && !tc.lookup_clip && (|tc.miss);
        wd_hit    = (wd == WD_W'(FILL_TO - 1));
        left_mask = pend_mask & ~bank_onehot(tc.mem_bank);
        prio_in   = (state == IDLE) ? tc.miss : left_mask;
    end

    assign tc.stall = (state != IDLE) || acc;

    de3d_tc_prio4 u_prio (
        .req (prio_in),
        .idx (prio_idx),
        .any (prio_any)
    );

    always_ff @(posedge de_clk or negedge de_rstn) begin
        if (!de_rstn) begin
            state          <= IDLE;
            pend_mask      <= '0;
            tag_q          <= '0;
            mip_q          <= '0;
            wd             <= '0;
            tc.mem_req     <= 1'b0;
            tc.mem_bank    <= '0;
            tc.mem_tag_adr <= '0;
            tc.mem_mipmap  <= '0;
            tc.tag_wr      <= '0;
            tc.texel_valid <= 1'b0;
            tc.fill_err    <= 1'b0;
            tc.miss_cnt    <= '0;
        end else begin
            tc.tag_wr      <= '0;
            tc.texel_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        pend_mask      <= tc.miss;
                        tag_q          <= tc.tag_adr;
                        mip_q          <= tc.mipmap;
                        tc.mem_req     <= 1'b1;
                        tc.mem_bank    <= prio_idx;
                        tc.mem_tag_adr <= tc.tag_adr[prio_idx*TAG_W +: TAG_W];
                        tc.mem_mipmap  <= tc.mipmap;
                        state          <= REQ;
                    end else if (tc.lookup_valid) begin
                        tc.texel_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (tc.mem_req && tc.mem_ack) begin
                        tc.mem_req <= 1'b0;
                        wd         <= '0;
                        state      <= WAIT_FILL;
                        if (tc.miss_cnt != '1)
                            tc.miss_cnt <= tc.miss_cnt + CNT_W'(1);
                    end
                end
                WAIT_FILL: begin
                    if (tc.fill_done || wd_hit) begin
                        if (tc.fill_done) tc.tag_wr   <= bank_onehot(tc.mem_bank);
                        else              tc.fill_err <= 1'b1;
                        pend_mask <= left_mask;
                        if (prio_any) begin
                            tc.mem_req     <= 1'b1;
                            tc.mem_bank    <= prio_idx;
                            tc.mem_tag_adr <= tag_q[prio_idx*TAG_W +: TAG_W];
                            tc.mem_mipmap  <= mip_q;
                            state          <= REQ;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                DONE: begin
                    tc.texel_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
